uart_loop_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_loop_fifo_sync_fifo.sv | 39 +++
 rtl/uart_loop_fifo.sv | 89 ++++++++
 tb/tb_uart_loop_fifo.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared transmit FSM states and ASCII case-mapping constants for the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO} tx_state_t;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;
endpackage

// File: rtl/uart_loop_fifo_sync_fifo.sv
// sync_fifo: wrap-bit pointer FIFO (in: clk rst_n wr_en wr_data rd_en; out: rd_data full empty count)
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_wp, r_rp;
  logic w_wr, w_rd;
  assign count = r_wp - r_rp;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign w_wr = wr_en & ~full;
  assign w_rd = rd_en & ~empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      rd_data <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + CNT_W'(1);
      if (w_rd) begin
        r_rp <= r_rp + CNT_W'(1);
        rd_data <= r_mem[r_rp[CNT_W-2:0]];
      end
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp[CNT_W-2:0]] <= wr_data;
endmodule

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: queue received words and replay them to the transmitter (in: recv/tx_busy/controls; out: send_en send_data fifo_count ovf_flag)
module uart_loop_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int BUSY_TO = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              recv_done,
  input  logic [DATA_W-1:0] recv_data,
  input  logic              tx_busy,
  input  logic              loop_en,
  input  logic              upcase_en,
  input  logic              ovf_clr,
  output logic              send_en,
  output logic [DATA_W-1:0] send_data,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              ovf_flag
);
  localparam int TO_W = $clog2(BUSY_TO + 1);
  tx_state_t r_state;
  logic r_d0, r_d1;
  logic [TO_W-1:0] r_to;
  logic w_push_req, w_wr, w_drop, w_rd, w_full, w_empty;
  logic [DATA_W-1:0] w_word, w_rd_data;
  assign w_push_req = r_d0 & ~r_d1;
  assign w_wr = w_push_req & loop_en & ~w_full;
  assign w_drop = w_push_req & loop_en & w_full;
  assign w_rd = (r_state == S_IDLE) & ~w_empty & ~tx_busy;
  generate
    if (DATA_W == 8) begin : g_up
      assign w_word = (upcase_en && recv_data >= ASCII_LC_A && recv_data <= ASCII_LC_Z)
                      ? (recv_data & ~ASCII_CASE_BIT) : recv_data;
    end else begin : g_raw
      assign w_word = recv_data;
    end
  endgenerate
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(sys_clk),
    .rst_n(sys_rst_n),
    .wr_en(w_wr),
    .wr_data(w_word),
    .rd_en(w_rd),
    .rd_data(w_rd_data),
    .full(w_full),
    .empty(w_empty),
    .count(fifo_count)
  );
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_d0 <= 1'b0;
      r_d1 <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      r_d0 <= recv_done;
      r_d1 <= r_d0;
      ovf_flag <= w_drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_flag;
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_to <= '0;
      send_en <= 1'b0;
      send_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_rd) r_state <= S_LOAD;
        S_LOAD: begin
          send_data <= w_rd_data;
          send_en <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          send_en <= 1'b0;
          r_to <= '0;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI:
          if (tx_busy) r_state <= S_WAIT_LO;
          else if (r_to == TO_W'(BUSY_TO - 1)) r_state <= S_IDLE;
          else r_to <= r_to + TO_W'(1);
        S_WAIT_LO: if (!tx_busy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_loop_fifo.sv
// tb_uart_loop_fifo: scoreboard bench with a queue model of the echo path and a frame-timed transmitter model
module tb_uart_loop_fifo;
  localparam int DEPTH = 16;
  logic sys_clk = 0, sys_rst_n = 0, recv_done = 0, loop_en = 1, upcase_en = 0, ovf_clr = 0;
  logic [7:0] recv_data = 0;
  logic tx_busy, send_en, ovf_flag;
  logic [7:0] send_data;
  logic [4:0] fifo_count;
  logic hold_busy = 0, mute = 0, model_busy = 0, model_ovf = 0, prev_en = 0;
  int frame_left = 0, total = 0, bad = 0, cyc = 0, sends = 0, send_cyc = 0, push_cyc = 0, s0;
  logic [7:0] exp_q[$];
  assign tx_busy = hold_busy | model_busy;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;
  uart_loop_fifo dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .recv_done(recv_done), .recv_data(recv_data),
    .tx_busy(tx_busy), .loop_en(loop_en), .upcase_en(upcase_en), .ovf_clr(ovf_clr),
    .send_en(send_en), .send_data(send_data), .fifo_count(fifo_count), .ovf_flag(ovf_flag)
  );
  function automatic logic [7:0] xf(input logic [7:0] b, input logic up);
    return (up && b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge sys_clk) begin
    if (send_en) begin
      sends++;
      send_cyc = cyc;
      chk("send_en_single_cycle", prev_en, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_send: got data %0h expected no send", send_data);
      end else chk("send_data", send_data, exp_q.pop_front());
      if (!mute) frame_left = 10;
    end else if (frame_left > 0) frame_left--;
    model_busy = frame_left > 0;
    prev_en = send_en;
  end
  task automatic recv(input logic [7:0] d, input bit clr_too = 0);
    bit drop;
    @(negedge sys_clk);
    recv_data = d;
    recv_done = 1;
    @(negedge sys_clk);
    push_cyc = cyc;
    if (clr_too) ovf_clr = 1;
    drop = loop_en && exp_q.size() >= DEPTH;
    if (drop) model_ovf = 1;
    else if (clr_too) model_ovf = 0;
    if (loop_en && !drop) exp_q.push_back(xf(d, upcase_en));
    @(negedge sys_clk);
    ovf_clr = 0;
    recv_done = 0;
    @(negedge sys_clk);
  endtask
  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge sys_clk);
    chk("drain_pending", exp_q.size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_send_en", send_en, 0);
    chk("rst_send_data", send_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", ovf_flag, 0);
    sys_rst_n = 1;
    repeat (3) @(negedge sys_clk);
    recv(8'h5A);
    wait_drain(50);
    chk("latency", send_cyc - push_cyc, 3);
    repeat (15) @(negedge sys_clk);
    chk("count_after_single", fifo_count, 0);
    upcase_en = 1;
    recv(8'h61);
    recv(8'h7A);
    recv(8'h7B);
    recv(8'h41);
    wait_drain(200);
    upcase_en = 0;
    repeat (15) @(negedge sys_clk);
    hold_busy = 1;
    for (int i = 0; i < 16; i++) recv(8'(i));
    chk("burst_count", fifo_count, exp_q.size());
    chk("burst_ovf", ovf_flag, model_ovf);
    recv(8'hAA);
    chk("drop_count", fifo_count, 16);
    chk("drop_ovf", ovf_flag, model_ovf);
    @(negedge sys_clk);
    ovf_clr = 1;
    @(negedge sys_clk);
    ovf_clr = 0;
    model_ovf = 0;
    @(negedge sys_clk);
    chk("ovf_cleared", ovf_flag, model_ovf);
    recv(8'hAA, 1);
    chk("drop_vs_clr_ovf", ovf_flag, model_ovf);
    chk("drop_vs_clr_count", fifo_count, 16);
    s0 = sends;
    hold_busy = 0;
    wait_drain(600);
    chk("burst_sends", sends - s0, 16);
    repeat (15) @(negedge sys_clk);
    recv(8'h77);
    wait_drain(50);
    hold_busy = 1;
    for (int i = 0; i < 5; i++) recv(8'h80 + 8'(i));
    chk("pre_reset_count", fifo_count, exp_q.size());
    #2 sys_rst_n = 0;
    #1;
    chk("async_rst_send_en", send_en, 0);
    chk("async_rst_send_data", send_data, 0);
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_ovf", ovf_flag, 0);
    exp_q.delete();
    model_ovf = 0;
    hold_busy = 0;
    @(negedge sys_clk);
    sys_rst_n = 1;
    s0 = sends;
    repeat (30) @(negedge sys_clk);
    chk("no_send_after_reset", sends - s0, 0);
    mute = 1;
    recv(8'h11);
    recv(8'h22);
    for (int i = 0; i < 50 && exp_q.size() > 1; i++) @(negedge sys_clk);
    repeat (55) @(negedge sys_clk);
    chk("timeout_not_early", exp_q.size(), 1);
    wait_drain(100);
    repeat (75) @(negedge sys_clk);
    mute = 0;
    loop_en = 0;
    s0 = sends;
    recv(8'h33);
    repeat (20) @(negedge sys_clk);
    chk("loop_off_sends", sends - s0, 0);
    chk("loop_off_count", fifo_count, 0);
    loop_en = 1;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 500 && exp_q.size() >= 6; j++) @(negedge sys_clk);
      upcase_en = 1'($urandom_range(0, 1));
      recv($urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'(8'h5F + $urandom_range(0, 29)));
      repeat ($urandom_range(0, 8)) @(negedge sys_clk);
    end
    wait_drain(2000);
    repeat (20) @(negedge sys_clk);
    chk("random_final_count", fifo_count, 0);
    chk("random_final_ovf", ovf_flag, model_ovf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
